// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI command queue: sequencer state encoding,
// command word field positions, CPU status word bit positions, the SPI clock
// divider used by the downstream driver, and a status packing helper.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_GAP       = 3'd4
    } spi_state_e;

    // Command word layout: {pwr, dc, byte}
    localparam int WORD_W  = 10;
    localparam int PWR_BIT = 9;
    localparam int DC_BIT  = 8;

    // CPU status word layout: {22'b0, ovf, tmo, busy, full, empty, level[4:0]}
    localparam int STAT_LEVEL_LSB = 0;
    localparam int STAT_LEVEL_W   = 5;
    localparam int STAT_EMPTY_BIT = 5;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_BUSY_BIT  = 7;
    localparam int STAT_TMO_BIT   = 8;
    localparam int STAT_OVF_BIT   = 9;

    // Divider of the SPI driver fed by this queue
    localparam int SPI_FREQDIV = 25;

    // GAP counter load values: the counter value is (gap cycles - 1)
    localparam logic [1:0] GAP_LOAD_PWR = 2'd1;
    localparam logic [1:0] GAP_LOAD_CMD = 2'd0;

    // Assemble the CPU-visible status word from its fields
    function automatic logic [31:0] pack_status(
        input logic       ovf,
        input logic       tmo,
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic [4:0] level
    );
        logic [31:0] word;
        word                                        = 32'd0;
        word[STAT_OVF_BIT]                          = ovf;
        word[STAT_TMO_BIT]                          = tmo;
        word[STAT_BUSY_BIT]                         = busy;
        word[STAT_FULL_BIT]                         = full;
        word[STAT_EMPTY_BIT]                        = empty;
        word[STAT_LEVEL_LSB +: STAT_LEVEL_W]        = level;
        return word;
    endfunction

endpackage

// File: rtl/spi_cmd_queue_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_queue_if
// Bundles the CPU write port, the CPU status word and the SPI driver handshake
// of the command queue.
//   wr_en, wr_data, clr_err : CPU -> queue
//   status                  : queue -> CPU
//   spi_start, spi_din      : queue -> SPI driver
//   spi_cs_n                : SPI driver -> queue (low while a byte shifts)
// Modport slave is the queue's view, master the surrounding system's view.
// -----------------------------------------------------------------------------
interface spi_cmd_queue_if;
    import spi_pkg::*;

    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              clr_err;
    logic              spi_cs_n;
    logic              spi_start;
    logic [WORD_W-1:0] spi_din;
    logic [31:0]       status;

    modport slave (
        input  wr_en,
        input  wr_data,
        input  clr_err,
        input  spi_cs_n,
        output spi_start,
        output spi_din,
        output status
    );

    modport master (
        output wr_en,
        output wr_data,
        output clr_err,
        output spi_cs_n,
        input  spi_start,
        input  spi_din,
        input  status
    );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock circular FIFO. Storage is not reset so it maps onto
// distributed/block RAM; pointers and level are reset synchronously.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset of pointers and level
//   push    : write din (accepted when not full, or when full with a pop)
//   pop     : drop the head entry (ignored when empty)
//   din     : write data
//   dout    : head entry (combinational read)
//   full    : level == DEPTH
//   empty   : level == 0
//   level   : occupied entries, one bit wider than the pointers
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests: a full FIFO still takes a write when the head leaves in the same cycle
    always_comb begin
        pop_ok_s  = pop && (level_r != LVL_ZERO);
        push_ok_s = push && ((level_r != LVL_FULL) || pop_ok_s);
    end

    // Storage write port (no reset so the array stays RAM-inferable)
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and level bookkeeping; pointers wrap naturally as DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (level_r == LVL_FULL);
    assign empty = (level_r == LVL_ZERO);
    assign level = level_r;

endmodule

// File: rtl/spi_cmd_queue.sv
// -----------------------------------------------------------------------------
// spi_cmd_queue
// Buffers 10-bit SPI command words written by the CPU and feeds them one at a
// time to an SPI byte driver, pacing on the driver's chip-select feedback.
// Power-on words (pwr=1) are not acknowledged by the driver and only get a
// fixed two-cycle gap. Overflow and acknowledge-timeout are sticky errors.
//   clk      : single clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : spi_cmd_queue_if.slave (CPU write/status + SPI handshake)
// -----------------------------------------------------------------------------
module spi_cmd_queue
    import spi_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    spi_cmd_queue_if.slave bus
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_ZERO = TW'(0);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    spi_state_e        state_r;
    spi_state_e        state_nxt_s;
    logic [TW-1:0]     tmo_cnt_r;
    logic [TW-1:0]     tmo_cnt_nxt_s;
    logic [1:0]        gap_cnt_r;
    logic [1:0]        gap_cnt_nxt_s;
    logic              issue_s;
    logic              tmo_evt_s;
    logic              ovf_evt_s;
    logic              busy_s;
    logic [4:0]        level5_s;

    logic [WORD_W-1:0] fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [LW-1:0]     fifo_level_s;

    logic              spi_start_r;
    logic [WORD_W-1:0] spi_din_r;
    logic              ovf_r;
    logic              tmo_r;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.wr_en),
        .pop     (issue_s),
        .din     (bus.wr_data),
        .dout    (fifo_dout_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    // Sequencer next-state and counter logic
    always_comb begin
        state_nxt_s   = state_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
        issue_s       = 1'b0;
        tmo_evt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issue_s = 1'b1;
                if (fifo_dout_s[PWR_BIT]) begin
                    // Driver ignores power-on words: no chip-select handshake
                    state_nxt_s   = ST_GAP;
                    gap_cnt_nxt_s = GAP_LOAD_PWR;
                end else begin
                    state_nxt_s   = ST_WAIT_LOW;
                    tmo_cnt_nxt_s = TMO_ZERO;
                end
            end
            ST_WAIT_LOW: begin
                if (!bus.spi_cs_n) begin
                    state_nxt_s   = ST_WAIT_HIGH;
                    tmo_cnt_nxt_s = TMO_ZERO;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s   = ST_IDLE;
                    tmo_cnt_nxt_s = TMO_ZERO;
                    tmo_evt_s     = 1'b1;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                if (bus.spi_cs_n) begin
                    state_nxt_s   = ST_GAP;
                    gap_cnt_nxt_s = GAP_LOAD_CMD;
                end else begin
                    state_nxt_s   = ST_WAIT_HIGH;
                end
            end
            ST_GAP: begin
                // Hold off until the driver is back in its wait state
                if (gap_cnt_r == 2'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                tmo_cnt_nxt_s = TMO_ZERO;
                gap_cnt_nxt_s = 2'd0;
            end
        endcase
    end

    // Sequencer state and counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= TMO_ZERO;
            gap_cnt_r <= 2'd0;
        end else begin
            state_r   <= state_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
        end
    end

    // Write to a full queue with no departing head loses the word
    always_comb begin
        ovf_evt_s = bus.wr_en && fifo_full_s && !issue_s;
    end

    // Registered SPI outputs and sticky error flags (a new error beats clr_err)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spi_start_r <= 1'b0;
            spi_din_r   <= {WORD_W{1'b0}};
            ovf_r       <= 1'b0;
            tmo_r       <= 1'b0;
        end else begin
            spi_start_r <= issue_s;
            if (issue_s) begin
                spi_din_r <= fifo_dout_s;
            end
            ovf_r <= ovf_evt_s | (ovf_r & ~bus.clr_err);
            tmo_r <= tmo_evt_s | (tmo_r & ~bus.clr_err);
        end
    end

    // Status decode from registered state
    always_comb begin
        busy_s   = !((state_r == ST_IDLE) && fifo_empty_s);
        level5_s = 5'(fifo_level_s);
    end

    assign bus.spi_start = spi_start_r;
    assign bus.spi_din   = spi_din_r;
    assign bus.status    = pack_status(ovf_r, tmo_r, busy_s, fifo_full_s, fifo_empty_s, level5_s);

endmodule

// File: tb/tb_spi_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_queue
// Directed bench for spi_cmd_queue with a behavioural SPI driver model and a
// scoreboard of expected spi_din words in write order.
// -----------------------------------------------------------------------------
module tb_spi_cmd_queue;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 8;
    localparam int M_NORMAL    = 0;   // cs_n low for low_len cycles after each non-pwr start
    localparam int M_HOLD      = 1;   // cs_n low after a start until mode changes
    localparam int M_DEAF      = 2;   // cs_n never goes low

    logic clk = 1'b0;
    logic reset_n;

    spi_cmd_queue_if bus();

    spi_cmd_queue #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_tests        = 0;
    int n_fail         = 0;
    int cyc            = 0;
    int n_starts       = 0;
    int last_start_cyc = -100;
    int cs_rise_cyc    = 0;
    int cs_left        = 0;
    int low_len        = 450;
    int model_mode     = M_NORMAL;
    logic [9:0] exp_q[$];

    initial forever #8 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI driver model
    initial begin
        bus.spi_cs_n = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.spi_start === 1'b1 && model_mode != M_DEAF && bus.spi_din[9] !== 1'b1) begin
                bus.spi_cs_n = 1'b0;
                cs_left      = (model_mode == M_HOLD) ? -1 : low_len;
            end else if (cs_left > 0) begin
                cs_left--;
                if (cs_left == 0) begin
                    bus.spi_cs_n = 1'b1;
                    cs_rise_cyc  = cyc;
                end
            end else if (cs_left < 0 && model_mode != M_HOLD) begin
                cs_left = 1;
            end
        end
    end

    // Output monitor: order against the scoreboard and minimum start spacing
    initial forever begin
        @(negedge clk);
        if (bus.spi_start === 1'b1) begin
            n_starts++;
            chk("start_spacing_ge3", 32'((cyc - last_start_cyc) >= 3), 32'd1);
            last_start_cyc = cyc;
            chk("start_has_pending_word", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("spi_din_order", 32'(bus.spi_din), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_word(input logic [9:0] d, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (accept) exp_q.push_back(d);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_start(input int max, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.spi_start !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.spi_start), 32'd1);
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (bus.status[7] !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < max), 32'd1);
    endtask

    task automatic wait_cs_high(input int max, input string tag);
        int n;
        n = 0;
        while (bus.spi_cs_n !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.spi_cs_n), 32'd1);
    endtask

    initial begin
        int s;
        int c;
        int n0;
        logic [9:0] d;

        reset_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 10'd0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_spi_start", 32'(bus.spi_start), 32'd0);
        chk("rst_spi_din", 32'(bus.spi_din), 32'd0);
        chk("rst_status", bus.status, 32'h0000_0020);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_spi_start", 32'(bus.spi_start), 32'd0);

        // Command word latency and gap after cs_n rises
        model_mode = M_NORMAL;
        low_len    = 450;
        push_word(10'h0AF, 1'b1);
        chk("cmd_level_1", 32'(bus.status[4:0]), 32'd1);
        chk("cmd_lat_t1", 32'(bus.spi_start), 32'd0);
        @(negedge clk);
        chk("cmd_lat_t2", 32'(bus.spi_start), 32'd0);
        @(negedge clk);
        chk("cmd_lat_t3", 32'(bus.spi_start), 32'd1);
        chk("cmd_din", 32'(bus.spi_din), 32'h0AF);
        low_len = 20;
        push_word(10'h155, 1'b1);
        wait_cs_high(600, "cmd_cs_rise");
        wait_start(20, "cmd_second_start");
        chk("cmd_start_after_cs_rise", 32'(cyc - cs_rise_cyc), 32'd4);
        wait_idle(200, "cmd_idle");

        // Power-on word: no handshake, two GAP cycles, no timeout
        model_mode = M_DEAF;
        push_word(10'h200, 1'b1);
        chk("pwr_lat_t1", 32'(bus.spi_start), 32'd0);
        @(negedge clk);
        chk("pwr_lat_t2", 32'(bus.spi_start), 32'd0);
        @(negedge clk);
        chk("pwr_lat_t3", 32'(bus.spi_start), 32'd1);
        chk("pwr_din", 32'(bus.spi_din), 32'h200);
        @(negedge clk);
        chk("pwr_gap_busy", 32'(bus.status[7]), 32'd1);
        @(negedge clk);
        chk("pwr_idle_status", bus.status, 32'h0000_0020);
        repeat (10) @(negedge clk);
        chk("pwr_no_tmo", 32'(bus.status[8]), 32'd0);

        // Overflow with stalled driver
        model_mode = M_HOLD;
        push_word(10'h101, 1'b1);
        wait_start(10, "ovf_first_start");
        for (int i = 0; i < 17; i++) begin
            push_word(10'h040 + 10'(i), i < 16);
        end
        chk("ovf_full_status", bus.status, 32'h0000_02D0);
        bus.clr_err = 1'b1;
        push_word(10'h3FF, 1'b0);
        bus.clr_err = 1'b0;
        chk("ovf_error_beats_clr", bus.status, 32'h0000_02D0);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("ovf_cleared", bus.status, 32'h0000_00D0);

        // Release the driver and write exactly in the pop cycle while full
        low_len    = 10;
        model_mode = M_NORMAL;
        wait_cs_high(10, "full_release_cs");
        c = cs_rise_cyc;
        while (cyc < c + 3) @(negedge clk);
        push_word(10'h0AA, 1'b1);
        chk("full_pop_push_status", bus.status, 32'h0000_00D0);
        wait_idle(1000, "full_drain_idle");
        chk("full_drain_empty_q", 32'(exp_q.size()), 32'd0);

        // Acknowledge timeout
        model_mode = M_DEAF;
        push_word(10'h013, 1'b1);
        push_word(10'h014, 1'b1);
        wait_start(10, "tmo_first_start");
        s = cyc;
        repeat (7) @(negedge clk);
        chk("tmo_not_yet", 32'(bus.status[8]), 32'd0);
        @(negedge clk);
        chk("tmo_set", 32'(bus.status[8]), 32'd1);
        wait_start(10, "tmo_next_start");
        chk("tmo_next_start_cycle", 32'(cyc - s), 32'd10);
        wait_idle(50, "tmo_idle");
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("tmo_cleared_status", bus.status, 32'h0000_0020);

        // Random burst with gaps, pointers wrap several times
        model_mode = M_NORMAL;
        low_len    = 3;
        for (int i = 0; i < 40; i++) begin
            d = 10'($urandom_range(1023, 0));
            push_word(d, 1'b1);
            repeat ($urandom_range(12, 6)) @(negedge clk);
        end
        wait_idle(500, "burst_idle");
        chk("burst_all_emitted", 32'(exp_q.size()), 32'd0);
        chk("burst_no_errors", 32'(bus.status[9:8]), 32'd0);

        // Reset during WAIT_HIGH with words queued
        model_mode = M_HOLD;
        push_word(10'h111, 1'b1);
        wait_start(10, "rstmid_start");
        for (int i = 0; i < 5; i++) begin
            push_word(10'h120 + 10'(i), 1'b1);
        end
        chk("rstmid_level5", 32'(bus.status[4:0]), 32'd5);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset_n    = 1'b1;
        low_len    = 5;
        model_mode = M_NORMAL;
        n0         = n_starts;
        @(negedge clk);
        chk("rstmid_first_cycle_start", 32'(bus.spi_start), 32'd0);
        chk("rstmid_status", bus.status, 32'h0000_0020);
        repeat (20) @(negedge clk);
        chk("rstmid_no_start", 32'(n_starts - n0), 32'd0);
        push_word(10'h0C3, 1'b1);
        wait_start(10, "rstmid_new_start");
        chk("rstmid_new_din", 32'(bus.spi_din), 32'h0C3);
        wait_idle(100, "rstmid_idle");
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
